// File: rtl/cozy_cpu_core.sv
// -----------------------------------------------------------------------------
// cozy_cpu_core
//   Small 16-bit multi-cycle CPU core. A single synchronous word-wide memory
//   port carries both instruction fetch and data access. Reads have one cycle
//   of latency. Writes use per-byte enables.
//
//   Optional feature macro: COZY_CPU_SHIFT_EN
//     defined   -> opcodes 0xE/0xF are SHL/SHR (logical)
//     undefined -> opcodes 0xE/0xF execute as NOP
//
//   Ports (cozy_cpu_core):
//     clk       in   1   system clock, rising edge
//     reset_n   in   1   synchronous active-low reset
//     mem_addr  out 16   word address (fetch or data)
//     mem_bwe   out  2   byte write enables, [0]=7:0, [1]=15:8, 00=read
//     mem_dout  out 16   write data
//     mem_din   in  16   read data, valid one cycle after mem_addr
//
//   Ports (cozy_cpu_regfile, instantiated as REG):
//     clk, reset_n        clock and synchronous active-low reset
//     i_we/i_waddr/i_wdata  single write port
//     i_a/b/c_addr        three combinational read addresses
//     o_a/b/c_data        matching read data
// -----------------------------------------------------------------------------

module cozy_cpu_regfile (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_we,
    input  logic [3:0]  i_waddr,
    input  logic [15:0] i_wdata,
    input  logic [3:0]  i_a_addr,
    input  logic [3:0]  i_b_addr,
    input  logic [3:0]  i_c_addr,
    output logic [15:0] o_a_data,
    output logic [15:0] o_b_data,
    output logic [15:0] o_c_data
);
    // Registers are kept as individual named signals so they can be probed
    // hierarchically as REG.r0 .. REG.r15.
    logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic [15:0] r8, r9, r10, r11, r12, r13, r14, r15;
    logic [15:0][15:0] w_regs;

    assign w_regs = {r15, r14, r13, r12, r11, r10, r9, r8,
                     r7, r6, r5, r4, r3, r2, r1, r0};

    // Reads are combinational, so an instruction that names the same register
    // as source and destination sees the value from before its own write.
    assign o_a_data = w_regs[i_a_addr];
    assign o_b_data = w_regs[i_b_addr];
    assign o_c_data = w_regs[i_c_addr];

    // NOTE: this register file is reset explicitly because software relies on
    // r0..r15 reading zero after reset; a plain RAM array could not be cleared
    // in one cycle, which is why it is built from flops.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r0  <= '0; r1  <= '0; r2  <= '0; r3  <= '0;
            r4  <= '0; r5  <= '0; r6  <= '0; r7  <= '0;
            r8  <= '0; r9  <= '0; r10 <= '0; r11 <= '0;
            r12 <= '0; r13 <= '0; r14 <= '0; r15 <= '0;
        end else if (i_we) begin
            case (i_waddr)
                4'd0:  r0  <= i_wdata;
                4'd1:  r1  <= i_wdata;
                4'd2:  r2  <= i_wdata;
                4'd3:  r3  <= i_wdata;
                4'd4:  r4  <= i_wdata;
                4'd5:  r5  <= i_wdata;
                4'd6:  r6  <= i_wdata;
                4'd7:  r7  <= i_wdata;
                4'd8:  r8  <= i_wdata;
                4'd9:  r9  <= i_wdata;
                4'd10: r10 <= i_wdata;
                4'd11: r11 <= i_wdata;
                4'd12: r12 <= i_wdata;
                4'd13: r13 <= i_wdata;
                4'd14: r14 <= i_wdata;
                4'd15: r15 <= i_wdata;
            endcase
        end
    end
endmodule

module cozy_cpu_core #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [15:0] mem_addr,
    output logic [1:0]  mem_bwe,
    output logic [15:0] mem_dout,
    input  logic [15:0] mem_din
);
    typedef enum logic [2:0] {
        S_RESET   = 3'b000,
        S_FETCH   = 3'b001,
        S_DECODE  = 3'b010,
        S_EXECUTE = 3'b011,
        S_LOAD    = 3'b100,
        S_LOAD_WB = 3'b101,
        S_HALT    = 3'b110
    } state_t;

    state_t      state, w_state_next;
    logic [15:0] r_pc, r_ir;
    logic [15:0] w_pc_next, w_addr, w_dout, w_rf_wdata, w_br_target;
    logic [15:0] w_rd_val, w_rs_val, w_rt_val;
    logic [1:0]  w_bwe;
    logic        w_rf_we;
    logic [3:0]  w_op, w_rd, w_rs, w_rt;
    logic [7:0]  w_imm8;

    assign w_op   = r_ir[15:12];
    assign w_rd   = r_ir[11:8];
    assign w_rs   = r_ir[7:4];
    assign w_rt   = r_ir[3:0];
    assign w_imm8 = r_ir[7:0];

    // PC has already been incremented in DECODE, so branches are relative to
    // the instruction after the branch.
    assign w_br_target = r_pc + {{8{w_imm8[7]}}, w_imm8};

    cozy_cpu_regfile REG (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_we     (w_rf_we),
        .i_waddr  (w_rd),
        .i_wdata  (w_rf_wdata),
        .i_a_addr (w_rd),
        .i_b_addr (w_rs),
        .i_c_addr (w_rt),
        .o_a_data (w_rd_val),
        .o_b_data (w_rs_val),
        .o_c_data (w_rt_val)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_RESET;
            r_pc  <= RESET_PC;
            r_ir  <= '0;
        end else begin
            state <= w_state_next;
            r_pc  <= w_pc_next;
            if (state == S_DECODE) begin
                r_ir <= mem_din;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next = state;
        w_pc_next    = r_pc;
        w_addr       = r_pc;
        w_bwe        = 2'b00;
        w_dout       = 16'h0000;
        w_rf_we      = 1'b0;
        w_rf_wdata   = 16'h0000;

        case (state)
            S_RESET:  w_state_next = S_FETCH;
            S_FETCH:  w_state_next = S_DECODE;
            S_DECODE: begin
                w_state_next = S_EXECUTE;
                w_pc_next    = r_pc + 16'd1;
            end
            S_EXECUTE: begin
                w_state_next = S_FETCH;
                case (w_op)
                    4'h0: if (w_rt == 4'h1) w_state_next = S_HALT;
                    4'h1: begin w_rf_we = 1'b1; w_rf_wdata = {8'h00, w_imm8}; end
                    4'h2: begin w_rf_we = 1'b1; w_rf_wdata = {w_imm8, w_rd_val[7:0]}; end
                    4'h3: begin w_rf_we = 1'b1; w_rf_wdata = w_rs_val + w_rt_val; end
                    4'h4: begin w_rf_we = 1'b1; w_rf_wdata = w_rs_val - w_rt_val; end
                    4'h5: begin w_rf_we = 1'b1; w_rf_wdata = w_rs_val & w_rt_val; end
                    4'h6: begin w_rf_we = 1'b1; w_rf_wdata = w_rs_val | w_rt_val; end
                    4'h7: begin w_rf_we = 1'b1; w_rf_wdata = w_rs_val ^ w_rt_val; end
                    4'h8: begin
                        // Address goes out now; data returns during LOAD and
                        // is captured in LOAD_WB while the address is held.
                        w_addr       = w_rs_val;
                        w_state_next = S_LOAD;
                    end
                    4'h9: begin w_addr = w_rs_val; w_bwe = 2'b11; w_dout = w_rt_val; end
                    4'hA: begin w_addr = w_rs_val; w_bwe = 2'b01; w_dout = w_rt_val; end
                    4'hB: w_pc_next = w_rs_val;
                    4'hC: if (w_rd_val == 16'h0000) w_pc_next = w_br_target;
                    4'hD: if (w_rd_val != 16'h0000) w_pc_next = w_br_target;
`ifdef COZY_CPU_SHIFT_EN
                    4'hE: begin w_rf_we = 1'b1; w_rf_wdata = w_rs_val << w_rt_val[3:0]; end
                    4'hF: begin w_rf_we = 1'b1; w_rf_wdata = w_rs_val >> w_rt_val[3:0]; end
`else
                    4'hE, 4'hF: ;
`endif
                    default: ;
                endcase
            end
            S_LOAD: begin
                w_addr       = w_rs_val;
                w_state_next = S_LOAD_WB;
            end
            S_LOAD_WB: begin
                w_addr       = w_rs_val;
                w_rf_we      = 1'b1;
                w_rf_wdata   = mem_din;
                w_state_next = S_FETCH;
            end
            S_HALT:  w_state_next = S_HALT;
            default: w_state_next = S_RESET;
        endcase
    end

    // The memory has no reset of its own: masking the enables with reset_n
    // guarantees a store interrupted by reset never reaches the array.
    assign mem_addr = w_addr;
    assign mem_bwe  = reset_n ? w_bwe  : 2'b00;
    assign mem_dout = reset_n ? w_dout : 16'h0000;
endmodule

// File: tb/tb_cozy_cpu_core.sv
// -----------------------------------------------------------------------------
// tb_cozy_cpu_core
//   Self-checking bench for cozy_cpu_core. Directed programs cover reset,
//   ALU, load/store, branches, PC wrap, reset during a store and the optional
//   shift ops (COZY_CPU_SHIFT_EN). Random programs are compared against an
//   instruction-level interpreter of the ISA.
// -----------------------------------------------------------------------------

module tb_cozy_cpu_core;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] mem_addr, mem_dout, mem_din;
    logic [1:0]  mem_bwe;

    always #5 clk = ~clk;

    cozy_cpu_core #(.RESET_PC(16'h0000)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .mem_addr (mem_addr),
        .mem_bwe  (mem_bwe),
        .mem_dout (mem_dout),
        .mem_din  (mem_din)
    );

    // Synchronous memory with a backdoor load port used while the core is held in reset.
    logic [15:0] mem [0:65535];
    logic        bd_we = 1'b0;
    logic [15:0] bd_addr = '0, bd_data = '0;

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else begin
            if (mem_bwe[0]) mem[mem_addr][7:0]  <= mem_dout[7:0];
            if (mem_bwe[1]) mem[mem_addr][15:8] <= mem_dout[15:8];
        end
        mem_din <= mem[mem_addr];
    end

    wire [15:0][15:0] w_dut_regs = {dut.REG.r15, dut.REG.r14, dut.REG.r13, dut.REG.r12,
                                    dut.REG.r11, dut.REG.r10, dut.REG.r9,  dut.REG.r8,
                                    dut.REG.r7,  dut.REG.r6,  dut.REG.r5,  dut.REG.r4,
                                    dut.REG.r3,  dut.REG.r2,  dut.REG.r1,  dut.REG.r0};

    // Trace of every address presented in FETCH.
    logic [15:0] fetch_q [$];
    int          fq_base;
    always @(negedge clk) begin
        if (reset_n === 1'b1 && dut.state == 3'b001) fetch_q.push_back(mem_addr);
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    logic [15:0] prog [$];

    task automatic bd_write(input logic [15:0] a, input logic [15:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Hold reset, clear 0x00..0xFF and load prog; caller releases reset.
    task automatic load_test();
        @(negedge clk);
        reset_n = 1'b0;
        for (int a = 0; a < 256; a++) bd_write(16'(a), (a < prog.size()) ? prog[a] : 16'h0000);
    endtask

    task automatic release_reset();
        fq_base = fetch_q.size();
        reset_n = 1'b1;
    endtask

    task automatic run_to_halt(input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (dut.state != 3'b110 && cyc < budget);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_state"}, 32'(dut.state), 32'h0);
        check({tag, "_bwe"},   32'(mem_bwe),   32'h0);
        check({tag, "_dout"},  32'(mem_dout),  32'h0);
        check({tag, "_addr"},  32'(mem_addr),  32'h0);
        for (int i = 0; i < 16; i++) check($sformatf("%s_r%0d", tag, i), 32'(w_dut_regs[i]), 32'h0);
    endtask

    task automatic check_fetches(input string tag, input logic [15:0] exp_q [$]);
        check({tag, "_nfetch"}, 32'(fetch_q.size() - fq_base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && fq_base + i < fetch_q.size(); i++)
            check($sformatf("%s_fetch%0d", tag, i), 32'(fetch_q[fq_base + i]), 32'(exp_q[i]));
    endtask

    // ---------------- instruction-level reference interpreter ----------------
    logic [15:0] m_reg [16];
    logic [15:0] m_mem [logic [15:0]];
    logic [15:0] m_fetch [$];
    int          m_cycles;

    function automatic logic [15:0] m_rd(input logic [15:0] a);
        return m_mem.exists(a) ? m_mem[a] : 16'h0000;
    endfunction

    task automatic model_run();
        logic [15:0] pc, ir, a, b, t;
        logic [3:0]  op, rd, rs, rt;
        bit          halted;
        m_mem.delete();
        foreach (prog[i]) m_mem[16'(i)] = prog[i];
        for (int i = 0; i < 16; i++) m_reg[i] = 16'h0000;
        m_fetch.delete();
        pc = 16'h0000; m_cycles = 1; halted = 0;   // one cycle spent in RESET
        for (int step = 0; step < 500 && !halted; step++) begin
            m_fetch.push_back(pc);
            ir = m_rd(pc);
            pc = pc + 16'd1;
            m_cycles += 3;
            op = ir[15:12]; rd = ir[11:8]; rs = ir[7:4]; rt = ir[3:0];
            a = m_reg[rs]; b = m_reg[rt];
            case (op)
                4'h0: if (rt == 4'h1) halted = 1;
                4'h1: m_reg[rd] = {8'h00, ir[7:0]};
                4'h2: m_reg[rd][15:8] = ir[7:0];
                4'h3: m_reg[rd] = a + b;
                4'h4: m_reg[rd] = a - b;
                4'h5: m_reg[rd] = a & b;
                4'h6: m_reg[rd] = a | b;
                4'h7: m_reg[rd] = a ^ b;
                4'h8: begin m_reg[rd] = m_rd(a); m_cycles += 2; end
                4'h9: m_mem[a] = b;
                4'hA: begin t = m_rd(a); m_mem[a] = {t[15:8], b[7:0]}; end
                4'hB: pc = a;
                4'hC: if (m_reg[rd] == 16'h0) pc = pc + {{8{ir[7]}}, ir[7:0]};
                4'hD: if (m_reg[rd] != 16'h0) pc = pc + {{8{ir[7]}}, ir[7:0]};
`ifdef COZY_CPU_SHIFT_EN
                4'hE: m_reg[rd] = a << b[3:0];
                4'hF: m_reg[rd] = a >> b[3:0];
`endif
                default: ;
            endcase
        end
    endtask

    task automatic gen_random(input int n);
        prog.delete();
        prog.push_back({8'h1F, 8'hC0 + 8'($urandom_range(0, 63))});   // r15 = data pointer
        for (int i = 0; i < n; i++) begin
            logic [3:0] rd, rs, rt;
            int k;
            rd = 4'($urandom_range(0, 14));
            rs = 4'($urandom_range(0, 15));
            rt = 4'($urandom());
            k  = $urandom_range(0, 9);
            case (k)
                0:    prog.push_back({4'h1, rd, 8'($urandom())});
                1:    prog.push_back({4'h2, rd, 8'($urandom())});
                2, 9: prog.push_back({4'($urandom_range(3, 7)), rd, rs, rt});
                3:    prog.push_back({4'($urandom_range(14, 15)), rd, rs, rt});
                4:    prog.push_back({4'h8, rd, 4'hF, rt});
                5:    prog.push_back({4'h9, rd, 4'hF, rt});
                6:    prog.push_back({4'hA, rd, 4'hF, rt});
                7:    prog.push_back({4'($urandom_range(12, 13)), rs, 8'($urandom_range(1, 3))});
                default: prog.push_back({4'h0, rd, rs, (rt == 4'h1) ? 4'h0 : rt});
            endcase
        end
        for (int i = 0; i < 5; i++) prog.push_back(16'h0001);
    endtask

    task automatic random_test(input int idx);
        int cyc;
        string tag;
        tag = $sformatf("rnd%0d", idx);
        gen_random(20);
        model_run();
        load_test();
        release_reset();
        run_to_halt(1000, cyc);
        check({tag, "_cycles"}, 32'(cyc), 32'(m_cycles));
        check({tag, "_state"}, 32'(dut.state), 32'h6);
        check_fetches(tag, m_fetch);
        for (int i = 0; i < 16; i++) check($sformatf("%s_r%0d", tag, i), 32'(w_dut_regs[i]), 32'(m_reg[i]));
        for (int a = 16'hC0; a < 16'h100; a++)
            check($sformatf("%s_mem%0h", tag, a), 32'(mem[a]), 32'(m_rd(16'(a))));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        // --- reset, LDL/LDH, HALT ---
        prog = '{16'h1155, 16'h21AA, 16'h0001};
        load_test();
        check_reset_state("rst0");
        release_reset();
        run_to_halt(100, cyc);
        check("t1_cycles", 32'(cyc), 32'd10);
        check("t1_r1", 32'(dut.REG.r1), 32'hAA55);
        repeat (3) @(negedge clk);
        check("t1_state", 32'(dut.state), 32'h6);
        check("t1_bwe", 32'(mem_bwe), 32'h0);
        check_fetches("t1", '{16'h0, 16'h1, 16'h2});

        // --- ALU, wrap-around arithmetic, same-register source/destination ---
        prog = '{16'h12FF, 16'h22FF, 16'h1302, 16'h3423, 16'h4532, 16'h7623,
                 16'h5723, 16'h6823, 16'h3333, 16'h0001};
        load_test();
        release_reset();
        run_to_halt(100, cyc);
        check("alu_add", 32'(dut.REG.r4), 32'h0001);
        check("alu_sub", 32'(dut.REG.r5), 32'h0003);
        check("alu_xor", 32'(dut.REG.r6), 32'hFFFD);
        check("alu_and", 32'(dut.REG.r7), 32'h0002);
        check("alu_or",  32'(dut.REG.r8), 32'hFFFF);
        check("alu_self", 32'(dut.REG.r3), 32'h0004);

        // --- ST / LD / STB ---
        prog = '{16'h1180, 16'h1234, 16'h2212, 16'h9012, 16'h8310,
                 16'h1299, 16'h22AB, 16'hA012, 16'h0001};
        load_test();
        release_reset();
        run_to_halt(100, cyc);
        check("mem_cycles", 32'(cyc), 32'd30);
        check("mem_ld", 32'(dut.REG.r3), 32'h1234);
        check("mem_stb", 32'(mem[16'h80]), 32'h1299);

        // --- BZ taken, BNZ not taken, JMP ---
        prog = '{16'hC102, 16'h1711, 16'h1722, 16'hD1FF, 16'h1833, 16'h1210,
                 16'hB020, 16'h1944, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0001};
        load_test();
        release_reset();
        run_to_halt(100, cyc);
        check("br_r7", 32'(dut.REG.r7), 32'h0);
        check("br_r8", 32'(dut.REG.r8), 32'h33);
        check("br_r9", 32'(dut.REG.r9), 32'h0);
        check_fetches("br", '{16'h0, 16'h3, 16'h4, 16'h5, 16'h6, 16'h10});

        // --- PC wrap 0xFFFF -> 0x0000 ---
        prog = '{16'hD603, 16'h12FF, 16'h22FF, 16'hB020, 16'h0001};
        load_test();
        bd_write(16'hFFFF, 16'h1666);
        release_reset();
        run_to_halt(100, cyc);
        check("wrap_r6", 32'(dut.REG.r6), 32'h66);
        check_fetches("wrap", '{16'h0, 16'h1, 16'h2, 16'h3, 16'hFFFF, 16'h0, 16'h4});

        // --- reset asserted during the EXECUTE of a store ---
        prog = '{16'h1180, 16'h125A, 16'h9012, 16'h0001};
        load_test();
        release_reset();
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (mem_bwe != 2'b11 && cyc < 50);
        check("abort_saw_store", 32'(mem_bwe), 32'h3);
        reset_n = 1'b0;
        #1;
        check("abort_bwe_masked", 32'(mem_bwe), 32'h0);
        @(negedge clk);
        check("abort_no_write", 32'(mem[16'h80]), 32'h0);
        check_reset_state("abort");
        @(negedge clk);
        release_reset();
        run_to_halt(100, cyc);
        check("abort_rerun_cycles", 32'(cyc), 32'd13);
        check("abort_rerun_mem", 32'(mem[16'h80]), 32'h005A);
        check_fetches("abort", '{16'h0, 16'h1, 16'h2, 16'h3});

        // --- optional shifts ---
        prog = '{16'h1101, 16'h2180, 16'h1201, 16'h1477, 16'hE412,
                 16'h1577, 16'hF512, 16'h0001};
        load_test();
        release_reset();
        run_to_halt(100, cyc);
        check("sh_cycles", 32'(cyc), 32'd25);
`ifdef COZY_CPU_SHIFT_EN
        check("sh_shl", 32'(dut.REG.r4), 32'h0002);
        check("sh_shr", 32'(dut.REG.r5), 32'h4000);
`else
        check("sh_shl_nop", 32'(dut.REG.r4), 32'h0077);
        check("sh_shr_nop", 32'(dut.REG.r5), 32'h0077);
`endif

        // --- random programs against the interpreter ---
        for (int t = 0; t < 8; t++) random_test(t);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
